unidade_load_store: RTL and testbench

UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

---
 rtl/pacote_riscv.sv | 34 +++
 rtl/alinhador_bytes.sv | 53 +++++
 rtl/unidade_load_store.sv | 131 +++++++++++++
 tb/tb_unidade_load_store.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_riscv.sv
// Shared definitions for the load/store unit: FSM states and funct3 width codes.
package pacote_riscv;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LE       = 3'd1,
    MODIFICA = 3'd2,
    ESCREVE  = 3'd3,
    FIM      = 3'd4
  } estado_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width code and alignment check; unsigned variants are load-only.
  function automatic logic formato_valido(input logic [2:0] f3, input logic escrita,
                                          input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~escrita;
      F3_HU:   ok = ~escrita & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alinhador_bytes.sv
// Little-endian lane extraction/extension for loads and lane merge for sb/sh.
module alinhador_bytes
  import pacote_riscv::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_palavra,
  input  logic [31:0] i_dado,
  output logic [31:0] o_carga,
  output logic [31:0] o_mescla
);

  logic [31:0] w_desl;
  logic [7:0]  w_byte;
  logic [15:0] w_meia;

  assign w_desl = i_palavra >> {i_lane, 3'b000};
  assign w_byte = w_desl[7:0];
  assign w_meia = w_desl[15:0];

  // Load result: pick the addressed lane and extend it.
  always_comb begin
    o_carga = i_palavra;
    case (i_funct3)
      F3_B:    o_carga = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_carga = {24'h000000, w_byte};
      F3_H:    o_carga = {{16{w_meia[15]}}, w_meia};
      F3_HU:   o_carga = {16'h0000, w_meia};
      default: o_carga = i_palavra;
    endcase
  end

  // Store merge: overwrite only the addressed lanes of the old word.
  always_comb begin
    o_mescla = i_palavra;
    case (i_funct3)
      F3_B: begin
        case (i_lane)
          2'd0:    o_mescla[7:0]   = i_dado[7:0];
          2'd1:    o_mescla[15:8]  = i_dado[7:0];
          2'd2:    o_mescla[23:16] = i_dado[7:0];
          default: o_mescla[31:24] = i_dado[7:0];
        endcase
      end
      F3_H: begin
        if (i_lane[1]) o_mescla[31:16] = i_dado[15:0];
        else           o_mescla[15:0]  = i_dado[15:0];
      end
      default: o_mescla = i_dado;
    endcase
  end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: validates the access, talks to the data memory with a
// held request/ack handshake, and does read-modify-write for sb/sh.
module unidade_load_store
  import pacote_riscv::*;
#(
  parameter int unsigned N_PALAVRAS = 32,
  parameter int unsigned END_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [2:0]       funct3,
  input  logic [31:0]      aluresult2,
  input  logic [31:0]      dado_rs2,
  output logic [31:0]      reddataM,
  output logic             pronto,
  output logic             erro,
  output logic [END_W-1:0] mem_end,
  output logic [31:0]      mem_wdata,
  output logic             mem_le,
  output logic             mem_es,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
);

  localparam logic [29:0] LIMITE = 30'(N_PALAVRAS);

  estado_t          r_estado, w_estado_prox;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lane;
  logic [END_W-1:0] r_end;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [31:0]      r_reddata;
  logic             r_erro;
  logic             r_escrita;

  logic        w_valido;
  logic [31:0] w_palavra;
  logic [31:0] w_carga;
  logic [31:0] w_mescla;

  // Full word index is compared so addresses past the memory wrap-around are rejected too.
  assign w_valido = (memread ^ memwrite)
                  & formato_valido(funct3, memwrite, aluresult2[1:0])
                  & (aluresult2[31:2] < LIMITE);

  assign w_palavra = (r_estado == MODIFICA) ? r_rdata : mem_rdata;

  alinhador_bytes u_alinhador (
    .i_funct3  (r_funct3),
    .i_lane    (r_lane),
    .i_palavra (w_palavra),
    .i_dado    (r_wdata),
    .o_carga   (w_carga),
    .o_mescla  (w_mescla)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_estado_prox;
  end

  // Next-state logic.
  always_comb begin
    w_estado_prox = r_estado;
    unique case (r_estado)
      OCIOSO: begin
        if (inicio) begin
          if (!w_valido)                          w_estado_prox = FIM;
          else if (memwrite && funct3 == F3_W)    w_estado_prox = ESCREVE;
          else                                    w_estado_prox = LE;
        end
      end
      LE:       if (mem_ack) w_estado_prox = r_escrita ? MODIFICA : FIM;
      MODIFICA: w_estado_prox = ESCREVE;
      ESCREVE:  if (mem_ack) w_estado_prox = FIM;
      FIM:      w_estado_prox = OCIOSO;
      default:  w_estado_prox = OCIOSO;
    endcase
  end

  // Datapath registers: request capture, read data, merged word, load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3  <= '0;
      r_lane    <= '0;
      r_end     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_reddata <= '0;
      r_erro    <= 1'b0;
      r_escrita <= 1'b0;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_erro <= ~w_valido;
            if (memread ^ memwrite) begin
              r_funct3  <= funct3;
              r_lane    <= aluresult2[1:0];
              r_end     <= aluresult2[END_W+1:2];
              r_wdata   <= dado_rs2;
              r_escrita <= memwrite;
            end
          end
        end
        LE: begin
          if (mem_ack) begin
            if (r_escrita) r_rdata   <= mem_rdata;
            else           r_reddata <= w_carga;
          end
        end
        MODIFICA: r_wdata <= w_mescla;
        default: ;
      endcase
    end
  end

  assign mem_le    = (r_estado == LE);
  assign mem_es    = (r_estado == ESCREVE);
  assign mem_end   = r_end;
  assign mem_wdata = r_wdata;
  assign reddataM  = r_reddata;
  assign pronto    = (r_estado == FIM);
  assign erro      = (r_estado == FIM) & r_erro;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a small handshaking memory model.
module tb_unidade_load_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] aluresult2;
  logic [31:0] dado_rs2;
  logic [31:0] reddataM;
  logic        pronto;
  logic        erro;
  logic [4:0]  mem_end;
  logic [31:0] mem_wdata;
  logic        mem_le;
  logic        mem_es;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;

  logic [31:0] mem [32];
  int ack_wait  = 0;
  int cnt       = 0;
  int n_reads   = 0;
  int n_writes  = 0;
  int n_req     = 0;
  logic both_seen = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  unidade_load_store #(.N_PALAVRAS(32), .END_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .memread    (memread),
    .memwrite   (memwrite),
    .funct3     (funct3),
    .aluresult2 (aluresult2),
    .dado_rs2   (dado_rs2),
    .reddataM   (reddataM),
    .pronto     (pronto),
    .erro       (erro),
    .mem_end    (mem_end),
    .mem_wdata  (mem_wdata),
    .mem_le     (mem_le),
    .mem_es     (mem_es),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ack_wait held cycles, data valid in the ack cycle.
  always @(negedge clk) begin
    if (mem_le && mem_es) both_seen = 1'b1;
    if (mem_le || mem_es) begin
      n_req++;
      if (cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_end];
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      cnt       = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_ack && rst_n) begin
      if (mem_es) begin
        mem[mem_end] = mem_wdata;
        n_writes++;
      end else if (mem_le) begin
        n_reads++;
      end
    end
  end

  // Issue one request and return cycles until pronto (0 on timeout) and erro.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic err);
    @(negedge clk);
    inicio = 1'b1; memread = rd; memwrite = wr; funct3 = f3;
    aluresult2 = addr; dado_rs2 = data;
    lat = 0; err = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin inicio = 1'b0; memread = 1'b0; memwrite = 1'b0; end
      if (pronto) begin lat = i; err = erro; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inicio = 1'b0; memread = 1'b0; memwrite = 1'b0;
    funct3 = 3'b0; aluresult2 = 32'h0; dado_rs2 = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({reddataM, mem_wdata} !== 64'h0) begin
      n_fails++; $display("FAIL reset_data: got %h/%h expected 0/0", reddataM, mem_wdata);
    end
    n_checks++;
    if ({pronto, erro, mem_le, mem_es, mem_end} !== 9'h0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b expected 0", {pronto, erro, mem_le, mem_es, mem_end});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    int lat; logic err; int r0;
    mem[2] = 32'hCAFEBABE; ack_wait = 1; r0 = n_reads;
    do_access(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, lat, err);
    n_checks++;
    if (lat !== 3) begin n_fails++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    n_checks++;
    if (err !== 1'b0) begin n_fails++; $display("FAIL lw_erro: got %b expected 0", err); end
    n_checks++;
    if (reddataM !== 32'hCAFEBABE) begin
      n_fails++; $display("FAIL lw_data: got %h expected cafebabe", reddataM);
    end
    n_checks++;
    if (n_reads - r0 !== 1) begin
      n_fails++; $display("FAIL lw_reads: got %0d expected 1", n_reads - r0);
    end
    @(negedge clk);
    n_checks++;
    if (pronto !== 1'b0) begin n_fails++; $display("FAIL pronto_pulse: got %b expected 0", pronto); end
  endtask

  task automatic test_load_sub();
    int lat; logic err;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h0B, 32'h0B, 32'h0A, 32'h0A};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012};
    mem[2] = 32'h80123456; ack_wait = 0;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 1'b0, f3s[i], ads[i], 32'h0, lat, err);
      n_checks++;
      if (reddataM !== exp[i] || lat !== 2 || err !== 1'b0) begin
        n_fails++;
        $display("FAIL load_sub[%0d]: got %h lat %0d erro %b expected %h lat 2 erro 0",
                 i, reddataM, lat, err, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    int lat; logic err; int r0, w0;
    mem[1] = 32'h11223344; ack_wait = 0; r0 = n_reads; w0 = n_writes;
    do_access(1'b0, 1'b1, 3'b001, 32'h06, 32'h0000BEEF, lat, err);
    n_checks++;
    if (mem[1] !== 32'hBEEF3344) begin
      n_fails++; $display("FAIL sh_word: got %h expected beef3344", mem[1]);
    end
    n_checks++;
    if (lat !== 4 || err !== 1'b0 || n_reads - r0 !== 1 || n_writes - w0 !== 1) begin
      n_fails++;
      $display("FAIL sh_flow: got lat %0d erro %b reads %0d writes %0d expected 4 0 1 1",
               lat, err, n_reads - r0, n_writes - w0);
    end
    mem[0] = 32'h0;
    do_access(1'b0, 1'b1, 3'b000, 32'h01, 32'h123456AA, lat, err);
    n_checks++;
    if (mem[0] !== 32'h0000AA00 || lat !== 4) begin
      n_fails++; $display("FAIL sb_word: got %h lat %0d expected 0000aa00 lat 4", mem[0], lat);
    end
    ack_wait = 2; r0 = n_reads; mem[4] = 32'h0;
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h12345678, lat, err);
    n_checks++;
    if (mem[4] !== 32'h12345678 || lat !== 4 || n_reads - r0 !== 0) begin
      n_fails++;
      $display("FAIL sw_flow: got %h lat %0d reads %0d expected 12345678 lat 4 reads 0",
               mem[4], lat, n_reads - r0);
    end
    ack_wait = 0;
    do_access(1'b1, 1'b0, 3'b001, 32'h06, 32'h0, lat, err);
    n_checks++;
    if (reddataM !== 32'hFFFFBEEF) begin
      n_fails++; $display("FAIL lh_after_sh: got %h expected ffffbeef", reddataM);
    end
  endtask

  task automatic test_reject();
    int lat; logic err; int q0; logic [31:0] keep;
    logic        rds [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        wrs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [6] = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b011, 3'b010};
    logic [31:0] ads [6] = '{32'h05, 32'h80, 32'h01, 32'h00, 32'h00, 32'h00};
    keep = reddataM;
    for (int i = 0; i < 6; i++) begin
      q0 = n_req;
      do_access(rds[i], wrs[i], f3s[i], ads[i], 32'hA5A5A5A5, lat, err);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || n_req - q0 !== 0 || reddataM !== keep) begin
        n_fails++;
        $display("FAIL reject[%0d]: got lat %0d erro %b req %0d data %h expected 1 1 0 %h",
                 i, lat, err, n_req - q0, reddataM, keep);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; int w0; logic seen;
    mem[3] = 32'h0; ack_wait = 6; w0 = n_writes;
    @(negedge clk);
    inicio = 1'b1; memread = 1'b0; memwrite = 1'b1; funct3 = 3'b010;
    aluresult2 = 32'h0C; dado_rs2 = 32'hDEADBEEF;
    @(negedge clk);
    inicio = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_es !== 1'b1) begin n_fails++; $display("FAIL rst_es_before: got %b expected 1", mem_es); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_es, mem_le, pronto, mem_end, mem_wdata} !== 40'h0) begin
      n_fails++;
      $display("FAIL rst_async: got es %b le %b pronto %b end %h wdata %h expected all 0",
               mem_es, mem_le, pronto, mem_end, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (pronto || mem_es) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0 || n_writes - w0 !== 0 || mem[3] !== 32'h0) begin
      n_fails++;
      $display("FAIL rst_no_resume: got seen %b writes %0d mem %h expected 0 0 0",
               seen, n_writes - w0, mem[3]);
    end
    ack_wait = 0;
    do_access(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, lat, err);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || reddataM !== 32'h80123456) begin
      n_fails++;
      $display("FAIL rst_next_lw: got lat %0d erro %b data %h expected 2 0 80123456",
               lat, err, reddataM);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic err; int w0;
    mem[5] = 32'h55AA55AA; ack_wait = 3; w0 = n_writes; lat = 0;
    @(negedge clk);
    inicio = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; aluresult2 = 32'h14;
    @(negedge clk);
    // Second strobe while the load is in LE; must have no effect.
    memread = 1'b0; memwrite = 1'b1; aluresult2 = 32'h18; dado_rs2 = 32'h0BAD0BAD;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) begin inicio = 1'b0; memwrite = 1'b0; end
      if (pronto) begin lat = i; break; end
    end
    n_checks++;
    if (lat !== 5 || reddataM !== 32'h55AA55AA || n_writes - w0 !== 0) begin
      n_fails++;
      $display("FAIL ignore_inicio: got lat %0d data %h writes %0d expected 5 55aa55aa 0",
               lat, reddataM, n_writes - w0);
    end
    do_access(1'b1, 1'b1, 3'b010, 32'h08, 32'h0, lat, err);
    n_checks++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fails++; $display("FAIL both_req: got lat %0d erro %b expected 1 1", lat, err);
    end
    n_checks++;
    if (both_seen !== 1'b0) begin
      n_fails++; $display("FAIL le_es_overlap: got %b expected 0", both_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_load_sub();
    test_store();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
